// File: rtl/move_link_ctrl_pkg.sv
// Shared types and default timing for the board-to-board move link controller.
package move_link_ctrl_pkg;
  localparam int MOVE_W          = 8;
  localparam int FRAME_CLKS_DEF  = 67_710;
  localparam int ACK_TIMEOUT_DEF = 6_500_000;
  localparam int MAX_RETRY_DEF   = 3;

  typedef enum logic [2:0] {
    IDLE,
    TX_MOVE,
    WAIT_ACK,
    COMMIT_L,
    COMMIT_R,
    TX_ECHO,
    ERROR
  } link_state_t;
endpackage

// File: rtl/move_link_ctrl_timer.sv
// Saturating up-counter with clear/enable; done is high while the count sits at MAX.
module move_link_ctrl_timer #(
  parameter int MAX        = 15,
  parameter bit START_DONE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] TC = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= START_DONE ? TC : '0;
    else if (clear)             count <= '0;
    else if (en && count != TC) count <= count + W'(1);
  end

  assign done = (count == TC);
endmodule

// File: rtl/move_link_ctrl.sv
// Move link sequencer: sends local moves and waits for the echo, commits and echoes remote moves.
//  state    | meaning
//  IDLE     | waiting for a local move (my turn) or a remote byte (their turn)
//  TX_MOVE  | local move latched, waiting for frame gap before sending
//  WAIT_ACK | local move sent, waiting for the opponent's echo or timeout
//  COMMIT_L | echo matched, local move handed to game_fsm
//  COMMIT_R | remote byte handed to game_fsm
//  TX_ECHO  | waiting for frame gap to echo the remote byte back
//  ERROR    | retries exhausted; absorbing until reset
module move_link_ctrl
  import move_link_ctrl_pkg::*;
#(
  parameter int PKT_LEN     = MOVE_W,
  parameter int FRAME_CLKS  = FRAME_CLKS_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               my_turn,
  input  logic               local_valid,
  input  logic [PKT_LEN-1:0] local_move,
  input  logic               rx_ready,
  input  logic [PKT_LEN-1:0] rx_data,
  output logic               tx_trigger,
  output logic [PKT_LEN-1:0] tx_data,
  output logic               move_valid,
  output logic [PKT_LEN-1:0] move_out,
  output logic               busy,
  output logic               link_error
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic [1:0]         rst_sync;
  logic               rst_n;
  link_state_t        state, state_nxt;
  logic [PKT_LEN-1:0] mv, mv_nxt, tx_hold, move_hold;
  logic [RW-1:0]      retry, retry_nxt;
  logic               gap_free, ack_done;

  // Assert asynchronously, release on the clock so all flops leave reset together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  move_link_ctrl_timer #(.MAX(FRAME_CLKS), .START_DONE(1'b1)) u_gap (
    .clk(clk_in), .rst_n(rst_n), .clear(tx_trigger), .en(1'b1), .done(gap_free)
  );

  move_link_ctrl_timer #(.MAX(ACK_TIMEOUT), .START_DONE(1'b0)) u_ack (
    .clk(clk_in), .rst_n(rst_n), .clear(tx_trigger),
    .en(state == WAIT_ACK && gap_free), .done(ack_done)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mv        <= '0;
      retry     <= '0;
      tx_hold   <= '0;
      move_hold <= '0;
    end else begin
      state <= state_nxt;
      mv    <= mv_nxt;
      retry <= retry_nxt;
      if (tx_trigger) tx_hold   <= mv;
      if (move_valid) move_hold <= mv;
    end
  end

  always_comb begin
    state_nxt  = state;
    mv_nxt     = mv;
    retry_nxt  = retry;
    tx_trigger = 1'b0;
    move_valid = 1'b0;
    case (state)
      IDLE: begin
        if (local_valid && my_turn) begin
          mv_nxt    = local_move;
          retry_nxt = '0;
          state_nxt = TX_MOVE;
        end else if (rx_ready && !my_turn) begin
          mv_nxt    = rx_data;
          state_nxt = COMMIT_R;
        end
      end
      TX_MOVE: begin
        if (gap_free) begin
          tx_trigger = 1'b1;
          state_nxt  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (rx_ready && rx_data == mv) begin
          state_nxt = COMMIT_L;
        end else if (rx_ready || ack_done) begin
          if (retry < RW'(MAX_RETRY)) begin
            retry_nxt = retry + RW'(1);
            state_nxt = TX_MOVE;
          end else begin
            state_nxt = ERROR;
          end
        end
      end
      COMMIT_L: begin
        move_valid = 1'b1;
        state_nxt  = IDLE;
      end
      COMMIT_R: begin
        move_valid = 1'b1;
        state_nxt  = TX_ECHO;
      end
      TX_ECHO: begin
        if (gap_free) begin
          tx_trigger = 1'b1;
          state_nxt  = IDLE;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs show the new byte on the pulse cycle itself, then hold it.
  assign tx_data    = tx_trigger ? mv : tx_hold;
  assign move_out   = move_valid ? mv : move_hold;
  assign busy       = (state != IDLE) && (state != ERROR);
  assign link_error = (state == ERROR);
endmodule

// File: tb/tb_move_link_ctrl.sv
// Bench for move_link_ctrl: time-based link model checked every cycle plus directed scenario checks.
module tb_move_link_ctrl;
  localparam int F   = 20;
  localparam int ACK = 100;
  localparam int MR  = 2;

  logic       clk_in = 1'b0, rst_n_in = 1'b0, my_turn = 1'b0;
  logic       local_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] local_move = '0, rx_data = '0;
  logic       tx_trigger, move_valid, busy, link_error;
  logic [7:0] tx_data, move_out;

  int checks = 0, failures = 0, cyc = 0;
  int trig_cyc[$], trig_dat[$], mv_cyc[$], mv_dat[$];
  int lv_cyc, rx_cyc, both_cyc;

  always #5 clk_in = ~clk_in;

  move_link_ctrl #(.PKT_LEN(8), .FRAME_CLKS(F), .ACK_TIMEOUT(ACK), .MAX_RETRY(MR)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .my_turn(my_turn),
    .local_valid(local_valid), .local_move(local_move),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_trigger(tx_trigger), .tx_data(tx_data),
    .move_valid(move_valid), .move_out(move_out),
    .busy(busy), .link_error(link_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Link model: what the link owes next, with frame spacing and ack deadline as absolute cycle numbers.
  typedef enum {M_IDLE, M_SEND, M_AWAIT, M_COMMIT_L, M_COMMIT_R, M_ECHO, M_ERR} job_t;
  job_t m_job = M_IDLE;
  int m_mv = 0, m_txh = 0, m_outh = 0, m_retries = 0, last_trig = -1000, deadline = 0;

  always @(negedge clk_in) begin
    bit e_trig, e_mv;
    int e_txd, e_mo;
    cyc++;
    if (!rst_n_in) begin
      m_job = M_IDLE; m_mv = 0; m_txh = 0; m_outh = 0; m_retries = 0; last_trig = -1000;
    end
    e_trig = rst_n_in && (m_job == M_SEND || m_job == M_ECHO) && (cyc - last_trig > F);
    e_mv   = (m_job == M_COMMIT_L || m_job == M_COMMIT_R);
    e_txd  = e_trig ? m_mv : m_txh;
    e_mo   = e_mv ? m_mv : m_outh;
    check("tx_trigger", tx_trigger, e_trig);
    check("tx_data",    tx_data,    e_txd);
    check("move_valid", move_valid, e_mv);
    check("move_out",   move_out,   e_mo);
    check("busy",       busy, (m_job != M_IDLE && m_job != M_ERR));
    check("link_error", link_error, (m_job == M_ERR));
    if (tx_trigger === 1'b1) begin trig_cyc.push_back(cyc); trig_dat.push_back(tx_data); end
    if (move_valid === 1'b1) begin mv_cyc.push_back(cyc); mv_dat.push_back(move_out); end
    if (local_valid && rx_ready) both_cyc = cyc;
    if (local_valid) lv_cyc = cyc;
    if (rx_ready) rx_cyc = cyc;
    if (rst_n_in) begin
      case (m_job)
        M_IDLE:
          if (local_valid && my_turn) begin m_mv = local_move; m_retries = 0; m_job = M_SEND; end
          else if (rx_ready && !my_turn) begin m_mv = rx_data; m_job = M_COMMIT_R; end
        M_SEND:
          if (e_trig) begin last_trig = cyc; m_txh = m_mv; deadline = cyc + F + 1 + ACK; m_job = M_AWAIT; end
        M_AWAIT:
          if (rx_ready && rx_data == m_mv) m_job = M_COMMIT_L;
          else if (rx_ready || cyc == deadline) begin
            if (m_retries < MR) begin m_retries++; m_job = M_SEND; end
            else m_job = M_ERR;
          end
        M_COMMIT_L: begin m_outh = m_mv; m_job = M_IDLE; end
        M_COMMIT_R: begin m_outh = m_mv; m_job = M_ECHO; end
        M_ECHO:
          if (e_trig) begin last_trig = cyc; m_txh = m_mv; m_job = M_IDLE; end
        default: ;
      endcase
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_local(input logic [7:0] v);
    local_valid = 1'b1; local_move = v;
    wait_cyc(1);
    local_valid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] v);
    rx_ready = 1'b1; rx_data = v;
    wait_cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_logs();
    trig_cyc.delete(); trig_dat.delete(); mv_cyc.delete(); mv_dat.delete();
  endtask

  initial begin
    int l, e, r1, r2;
    wait_cyc(3);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    rst_n_in = 1'b1;
    wait_cyc(5);

    // 1: local move, echoed after 40 cycles
    clear_logs(); my_turn = 1'b1;
    pulse_local(8'h3C); l = lv_cyc;
    wait_cyc(40); pulse_rx(8'h3C); e = rx_cyc;
    wait_cyc(5);
    check("t1_trig_cnt", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) begin
      check("t1_trig_cyc", trig_cyc[0], l + 1);
      check("t1_trig_dat", trig_dat[0], 8'h3C);
    end
    check("t1_mv_cnt", mv_cyc.size(), 1);
    if (mv_cyc.size() >= 1) check("t1_mv_cyc", mv_cyc[0], e + 1);
    check("t1_move_out", move_out, 8'h3C);
    check("t1_busy", busy, 1'b0);
    wait_cyc(30);

    // 2: remote move committed then echoed
    clear_logs(); my_turn = 1'b0;
    pulse_rx(8'h51); r1 = rx_cyc;
    wait_cyc(5);
    check("t2_mv_cnt", mv_cyc.size(), 1);
    if (mv_cyc.size() >= 1) check("t2_mv_cyc", mv_cyc[0], r1 + 1);
    check("t2_trig_cnt", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) begin
      check("t2_trig_cyc", trig_cyc[0], r1 + 2);
      check("t2_trig_dat", trig_dat[0], 8'h51);
    end
    check("t2_busy", busy, 1'b0);
    wait_cyc(30);

    // 3: no echo -> 3 sends spaced F+ACK+2, then sticky error
    clear_logs(); my_turn = 1'b1;
    pulse_local(8'h12); l = lv_cyc;
    wait_cyc(450);
    check("t3_trig_cnt", trig_cyc.size(), 3);
    if (trig_cyc.size() >= 3) begin
      check("t3_trig0", trig_cyc[0], l + 1);
      check("t3_gap1", trig_cyc[1] - trig_cyc[0], 122);
      check("t3_gap2", trig_cyc[2] - trig_cyc[1], 122);
    end
    check("t3_link_error", link_error, 1'b1);
    check("t3_mv_cnt", mv_cyc.size(), 0);
    pulse_local(8'h77);
    wait_cyc(30);
    check("t3_sticky_err", link_error, 1'b1);
    check("t3_sticky_trig", trig_cyc.size(), 3);
    rst_n_in = 1'b0; wait_cyc(3); rst_n_in = 1'b1; wait_cyc(5);
    check("t3_err_cleared", link_error, 1'b0);

    // 4: wrong echo forces retransmit after the gap, right echo commits
    clear_logs(); my_turn = 1'b1;
    pulse_local(8'h12);
    wait_cyc(8); pulse_rx(8'h13);
    wait_cyc(30); pulse_rx(8'h12); e = rx_cyc;
    wait_cyc(5);
    check("t4_trig_cnt", trig_cyc.size(), 2);
    if (trig_cyc.size() >= 2) check("t4_retx_cyc", trig_cyc[1], trig_cyc[0] + F + 1);
    check("t4_mv_cnt", mv_cyc.size(), 1);
    if (mv_cyc.size() >= 1) begin
      check("t4_mv_cyc", mv_cyc[0], e + 1);
      check("t4_mv_dat", mv_dat[0], 8'h12);
    end
    wait_cyc(30);

    // 5: echo waits for gap; local move while busy ignored; simultaneous pulses
    clear_logs(); my_turn = 1'b0;
    pulse_rx(8'h55); r1 = rx_cyc;
    wait_cyc(2);
    pulse_rx(8'h07); r2 = rx_cyc;
    my_turn = 1'b1;
    pulse_local(8'h66);
    wait_cyc(150);
    check("t5_trig_cnt", trig_cyc.size(), 2);
    if (trig_cyc.size() >= 2) begin
      check("t5_trig0", trig_cyc[0], r1 + 2);
      check("t5_echo_wait", trig_cyc[1], trig_cyc[0] + F + 1);
      check("t5_echo_dat", trig_dat[1], 8'h07);
    end
    if (mv_cyc.size() >= 2) check("t5_mv1_cyc", mv_cyc[1], r2 + 1);
    check("t5_mv_cnt", mv_cyc.size(), 2);
    clear_logs();
    local_valid = 1'b1; local_move = 8'h44; rx_ready = 1'b1; rx_data = 8'h99;
    wait_cyc(1);
    local_valid = 1'b0; rx_ready = 1'b0;
    wait_cyc(10); pulse_rx(8'h44);
    wait_cyc(5);
    check("t5b_trig_cnt", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) begin
      check("t5b_trig_cyc", trig_cyc[0], both_cyc + 1);
      check("t5b_trig_dat", trig_dat[0], 8'h44);
    end
    check("t5b_mv_cnt", mv_cyc.size(), 1);
    check("t5b_move_out", move_out, 8'h44);
    wait_cyc(30);

    // 6: reset during WAIT_ACK, then a clean exchange
    pulse_local(8'h5A);
    wait_cyc(10);
    #2 rst_n_in = 1'b0;
    #1;
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_move_out", move_out, 8'h00);
    check("t6_async_tx_data", tx_data, 8'h00);
    wait_cyc(3); rst_n_in = 1'b1; wait_cyc(5);
    clear_logs();
    pulse_local(8'h22); l = lv_cyc;
    wait_cyc(15); pulse_rx(8'h22); e = rx_cyc;
    wait_cyc(5);
    check("t6_trig_cnt", trig_cyc.size(), 1);
    if (trig_cyc.size() >= 1) check("t6_trig_cyc", trig_cyc[0], l + 1);
    check("t6_mv_cnt", mv_cyc.size(), 1);
    if (mv_cyc.size() >= 1) check("t6_mv_cyc", mv_cyc[0], e + 1);
    check("t6_move_out", move_out, 8'h22);
    check("t6_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
